// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
package imem_port_arbiter_pkg;

    // Owner of the single in-flight read whose response returns next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_AUX  = 2'd2
    } owner_e;

    // Canonical RV32 no-op (addi x0, x0, 0).
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive cycles the aux requester has been denied.
// starved_o forces the next aux request through ahead of fetch.
module imem_starve_ctr #(
    parameter int unsigned WAIT_MAX = 8,
    localparam int unsigned CW = $clog2(WAIT_MAX + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          aux_req_i,
    input  logic          aux_gnt_i,
    output logic          starved_o,
    output logic [CW-1:0] cnt_o
);

    localparam logic [CW-1:0] MAX = CW'(WAIT_MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear on service or idle, otherwise count up and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (!aux_req_i || aux_gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = (cnt_q == MAX);
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one synchronous instruction-memory port between fetch (priority)
// and an aux requester, and steers the single in-flight read response back
// to whichever side issued it. Fetch responses are dropped on redirect flush.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifReq,
    input  logic [XLEN-1:0]   ifAddr,
    input  logic              ifFlush,
    output logic              ifGnt,
    output logic              ifRvalid,
    output logic [XLEN-1:0]   ifRdata,
    input  logic              auxReq,
    input  logic              auxWe,
    input  logic [XLEN-1:0]   auxAddr,
    input  logic [XLEN-1:0]   auxWdata,
    input  logic [XLEN/8-1:0] auxBe,
    output logic              auxGnt,
    output logic              auxRvalid,
    output logic [XLEN-1:0]   auxRdata,
    output logic              memEn,
    output logic              memWe,
    output logic [XLEN/8-1:0] memBe,
    output logic [XLEN-1:0]   memAddr,
    output logic [XLEN-1:0]   memWdata,
    input  logic [XLEN-1:0]   memRdata
);

    logic aux_win, aux_gnt, if_gnt, starved;
    logic [$clog2(WAIT_MAX+1)-1:0] starve_cnt;
    owner_e owner_q, owner_d;

    imem_starve_ctr #(
        .WAIT_MAX (WAIT_MAX)
    ) u_starve (
        .clk_i     (clock),
        .rst_i     (reset),
        .aux_req_i (auxReq),
        .aux_gnt_i (aux_gnt),
        .starved_o (starved),
        .cnt_o     (starve_cnt)
    );

    // Same-cycle grant: aux wins when fetch is absent, flushed, or aux is starved.
    always_comb begin
        aux_win = auxReq && (!ifReq || ifFlush || starved);
        aux_gnt = !reset && aux_win;
        if_gnt  = !reset && ifReq && !ifFlush && !aux_win;
    end

    // Memory-port mux from the winner; idle drives zeros.
    always_comb begin
        memEn    = if_gnt || aux_gnt;
        memWe    = aux_gnt && auxWe;
        memAddr  = '0;
        memWdata = '0;
        memBe    = '0;
        if (if_gnt) begin
            memAddr = ifAddr;
            memBe   = '1;
        end else if (aux_gnt) begin
            memAddr  = auxAddr;
            memWdata = auxWdata;
            memBe    = auxWe ? auxBe : '1;
        end
    end

    // Owner next state: records who issued this cycle's read, if anyone.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (aux_gnt && !auxWe) begin
            owner_d = OWN_AUX;
        end
    end

    // Owner state register; reset discards any in-flight response.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign ifGnt     = if_gnt;
    assign auxGnt    = aux_gnt;
    assign ifRvalid  = !reset && (owner_q == OWN_IF) && !ifFlush;
    assign auxRvalid = !reset && (owner_q == OWN_AUX);
    assign ifRdata   = memRdata;
    assign auxRdata  = memRdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: table vectors, directed
// corner sequences and a randomized phase against a behavioural model.
module tb_imem_port_arbiter;

    localparam int unsigned WAIT_MAX = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifReq, ifFlush, ifGnt, ifRvalid;
    logic [31:0] ifAddr, ifRdata;
    logic        auxReq, auxWe, auxGnt, auxRvalid;
    logic [31:0] auxAddr, auxWdata, auxRdata;
    logic [3:0]  auxBe, memBe;
    logic        memEn, memWe;
    logic [31:0] memAddr, memWdata, memRdata;

    imem_port_arbiter #(
        .XLEN     (32),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ifReq     (ifReq),
        .ifAddr    (ifAddr),
        .ifFlush   (ifFlush),
        .ifGnt     (ifGnt),
        .ifRvalid  (ifRvalid),
        .ifRdata   (ifRdata),
        .auxReq    (auxReq),
        .auxWe     (auxWe),
        .auxAddr   (auxAddr),
        .auxWdata  (auxWdata),
        .auxBe     (auxBe),
        .auxGnt    (auxGnt),
        .auxRvalid (auxRvalid),
        .auxRdata  (auxRdata),
        .memEn     (memEn),
        .memWe     (memWe),
        .memBe     (memBe),
        .memAddr   (memAddr),
        .memWdata  (memWdata),
        .memRdata  (memRdata)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int unsigned i);
        return 32'hC0DE_0000 | (i << 2);
    endfunction

    // Environment memory: synchronous, 256 words, byte-enabled writes.
    logic [31:0] env_mem [256];
    logic        env_init = 1'b0;
    always @(posedge clock) begin
        if (!env_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
            env_init <= 1'b1;
        end else if (memEn) begin
            if (memWe) begin
                for (int b = 0; b < 4; b++)
                    if (memBe[b]) env_mem[memAddr[9:2]][8*b +: 8] <= memWdata[8*b +: 8];
            end else begin
                memRdata <= env_mem[memAddr[9:2]];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference state.
    logic [31:0] ref_mem [256];
    int unsigned streak = 0;
    logic        pend_valid = 1'b0, pend_if = 1'b0;
    logic [31:0] pend_data = '0;
    logic        m_ig, m_ag;
    int          reads_issued = 0, reads_dropped = 0, rv_seen = 0;

    // Computes expected outputs for the current cycle, compares, then
    // advances the model to the state after the coming clock edge.
    task automatic model_check();
        logic e_ir, e_ar, e_en, e_we;
        logic [31:0] e_addr;
        e_ir = 1'b0; e_ar = 1'b0;
        if (reset) begin
            m_ag = 1'b0;
            m_ig = 1'b0;
        end else begin
            m_ag = auxReq && (!ifReq || ifFlush || streak == WAIT_MAX);
            m_ig = ifReq && !ifFlush && !m_ag;
            e_ir = pend_valid && pend_if && !ifFlush;
            e_ar = pend_valid && !pend_if;
        end
        e_en   = m_ig || m_ag;
        e_we   = m_ag && auxWe;
        e_addr = m_ig ? ifAddr : (m_ag ? auxAddr : 32'h0);
        chk("ifGnt", 64'(ifGnt), 64'(m_ig));
        chk("auxGnt", 64'(auxGnt), 64'(m_ag));
        chk("one_gnt", 64'(ifGnt && auxGnt), 64'(0));
        chk("ifRvalid", 64'(ifRvalid), 64'(e_ir));
        chk("auxRvalid", 64'(auxRvalid), 64'(e_ar));
        chk("memEn", 64'(memEn), 64'(e_en));
        chk("memWe", 64'(memWe), 64'(e_we));
        chk("memAddr", 64'(memAddr), 64'(e_addr));
        if (e_ir) chk("ifRdata", 64'(ifRdata), 64'(pend_data));
        if (e_ar) chk("auxRdata", 64'(auxRdata), 64'(pend_data));
        if (e_en && !e_we) chk("memBe_rd", 64'(memBe), 64'(4'hF));
        if (e_we) begin
            chk("memBe_wr", 64'(memBe), 64'(auxBe));
            chk("memWdata", 64'(memWdata), 64'(auxWdata));
        end
        rv_seen += int'(ifRvalid) + int'(auxRvalid);
        if (pend_valid && (reset || (pend_if && ifFlush))) reads_dropped++;
        if (reset) begin
            pend_valid = 1'b0;
            streak     = 0;
        end else begin
            pend_valid = m_ig || (m_ag && !auxWe);
            pend_if    = m_ig;
            pend_data  = m_ig ? ref_mem[ifAddr[9:2]] : ref_mem[auxAddr[9:2]];
            if (pend_valid) reads_issued++;
            if (e_we)
                for (int b = 0; b < 4; b++)
                    if (auxBe[b]) ref_mem[auxAddr[9:2]][8*b +: 8] = auxWdata[8*b +: 8];
            if (auxReq && !m_ag) streak = (streak < WAIT_MAX) ? streak + 1 : WAIT_MAX;
            else streak = 0;
        end
    endtask

    task automatic mid();
        #4;
        model_check();
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ifReq = 0; ifFlush = 0; auxReq = 0; auxWe = 0;
    endtask

    typedef struct {
        logic ir, fl, ar, aw;
        logic e_ig, e_ag, e_we;
    } vec_t;

    vec_t vt [10];
    logic got;
    int   n;
    logic ip, ap;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        reset = 1; idle();
        ifAddr = '0; auxAddr = '0; auxWdata = '0; auxBe = '0;
        adv();
        // Reset state: nothing granted or valid while reset is high.
        mid();
        chk("rst_ifGnt", 64'(ifGnt), 0);
        chk("rst_memEn", 64'(memEn), 0);
        adv();
        mid(); adv();
        reset = 0;

        // Single-cycle grant vectors (streak stays below WAIT_MAX).
        vt[0] = '{1,0,0,0, 1,0,0};
        vt[1] = '{0,0,1,0, 0,1,0};
        vt[2] = '{0,0,1,1, 0,1,1};
        vt[3] = '{1,0,1,1, 1,0,0};
        vt[4] = '{1,1,1,1, 0,1,1};
        vt[5] = '{1,1,0,0, 0,0,0};
        vt[6] = '{0,1,0,0, 0,0,0};
        vt[7] = '{1,0,1,1, 1,0,0};
        vt[8] = '{1,0,1,1, 1,0,0};
        vt[9] = '{0,0,1,1, 0,1,1};
        auxAddr = 32'h200; auxWdata = 32'h1234_5678; auxBe = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            ifReq = vt[i].ir; ifFlush = vt[i].fl; auxReq = vt[i].ar; auxWe = vt[i].aw;
            ifAddr = 32'h100 + 32'(i * 4);
            mid();
            chk($sformatf("vec%0d_ifGnt", i), 64'(ifGnt), 64'(vt[i].e_ig));
            chk($sformatf("vec%0d_auxGnt", i), 64'(auxGnt), 64'(vt[i].e_ag));
            chk($sformatf("vec%0d_memWe", i), 64'(memWe), 64'(vt[i].e_we));
            adv();
        end
        idle(); mid(); adv();

        // Fetch-only streaming reads of words 0..3.
        for (int i = 0; i < 5; i++) begin
            ifReq = (i < 4); ifAddr = 32'(i * 4);
            mid();
            if (i < 4) chk("fetch_gnt", 64'(ifGnt), 1);
            if (i > 0) begin
                chk("fetch_rvalid", 64'(ifRvalid), 1);
                chk("fetch_rdata", 64'(ifRdata), 64'(init_word(i - 1)));
            end
            adv();
        end
        idle();

        // Aux write then read back.
        auxReq = 1; auxWe = 1; auxAddr = 32'h40; auxWdata = 32'hDEAD_BEEF; auxBe = 4'hF;
        mid();
        chk("auxwr_gnt", 64'(auxGnt), 1);
        chk("auxwr_memWe", 64'(memWe), 1);
        adv();
        idle(); mid(); adv();
        auxReq = 1; auxWe = 0; auxAddr = 32'h40;
        mid(); chk("auxrd_gnt", 64'(auxGnt), 1); adv();
        idle();
        mid();
        chk("auxrd_rvalid", 64'(auxRvalid), 1);
        chk("auxrd_rdata", 64'(auxRdata), 64'(32'hDEAD_BEEF));
        adv();

        // Starvation: fetch holds the port for WAIT_MAX cycles, then aux wins.
        ifReq = 1; auxReq = 1; auxWe = 0; auxAddr = 32'h80;
        n = 0; got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            ifAddr = 32'(c * 4);
            mid();
            if (auxGnt) begin
                got = 1;
                chk("starve_if_grants", 64'(n), 64'(WAIT_MAX));
            end else if (ifGnt) begin
                n++;
            end
            adv();
        end
        chk("starve_aux_gnt", 64'(got), 1);
        idle();
        mid(); chk("starve_cnt_clear", 64'(dut.starve_cnt), 0); adv();

        // Flush in response cycle, then flush in grant cycle with aux pending.
        ifReq = 1; ifAddr = 32'h10;
        mid(); chk("fl_gnt", 64'(ifGnt), 1); adv();
        ifReq = 0; ifFlush = 1;
        mid(); chk("fl_rvalid_killed", 64'(ifRvalid), 0); adv();
        ifReq = 1; ifAddr = 32'h14; auxReq = 1; auxWe = 0; auxAddr = 32'h44;
        mid();
        chk("fl_aux_gnt", 64'(auxGnt), 1);
        chk("fl_if_blocked", 64'(ifGnt), 0);
        adv();
        ifReq = 0; auxReq = 0;
        mid();
        chk("fl_aux_rvalid", 64'(auxRvalid), 1);
        chk("fl_aux_rdata", 64'(auxRdata), 64'(init_word(17)));
        adv();
        idle();

        // Reset the cycle after an aux read grant.
        auxReq = 1; auxWe = 0; auxAddr = 32'h48;
        mid(); chk("rs_aux_gnt", 64'(auxGnt), 1); adv();
        reset = 1; ifReq = 1; ifAddr = 32'h20;
        mid();
        chk("rs_aux_rvalid", 64'(auxRvalid), 0);
        chk("rs_gnts", 64'({ifGnt, auxGnt, memEn}), 0);
        adv();
        mid(); adv();
        reset = 0; idle();
        mid();
        chk("rs_after_rvalid", 64'({ifRvalid, auxRvalid}), 0);
        adv();

        // Randomized traffic; requesters hold until granted.
        ip = 0; ap = 0;
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!ip && $urandom_range(0, 3) != 0) begin
                ip = 1;
                ifAddr = 32'($urandom_range(0, 255)) << 2;
            end
            if (!ap && $urandom_range(0, 2) == 0) begin
                ap = 1;
                auxWe    = 1'($urandom_range(0, 1));
                auxAddr  = 32'($urandom_range(0, 255)) << 2;
                auxWdata = $urandom;
                auxBe    = 4'($urandom_range(1, 15));
            end
            ifReq   = ip;
            auxReq  = ap;
            ifFlush = ($urandom_range(0, 7) == 0);
            mid();
            if (m_ig) ip = 0;
            if (m_ag) ap = 0;
            adv();
        end
        reset = 0; idle();
        for (int c = 0; c < 3; c++) begin
            mid(); adv();
        end
        chk("rvalid_count", 64'(rv_seen), 64'(reads_issued - reads_dropped));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
